retire_monitor: RTL and testbench

//  Observes the CPU retire stream (retire_valid_reg / retire_addr_reg) and decides when a run ends:

---
 rtl/retire_monitor.sv | 188 ++++++++++++++++++
 tb/tb_retire_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_monitor.sv
// retire_monitor: watches the CPU retire stream and decides how a run ends: clean
//    halt (after an optional drain), cycle-budget timeout, or no-retire deadlock.
//    It also keeps saturating cycle and retire counters and the last counted retire PC.
// Ports: clk/rst (async, active-high), start (IDLE->RUN pulse), retire_valid/retire_addr
//    (retire stream), state/done/timeout/deadlock (registered status), cycle_count,
//    retire_count, last_addr, hist_idx/hist_addr (retire history read port).
// Optional build macro RETIRE_MONITOR_HIST_EN adds a HIST_DEPTH-entry history of
//    counted retire addresses. Without it hist_idx is unused and hist_addr reads 0.
module retire_monitor #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    CNT_WIDTH    = 32,
   parameter logic [ADDR_WIDTH-1:0] HALT_ADDR    = 'h0000_FFFC,
   parameter int                    DRAIN_CYCLES = 4,
   parameter int                    MAX_CYCLES   = 6000,
   parameter int                    STALL_LIMIT  = 256,
   parameter int                    HIST_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          retire_valid,
   input  logic [ADDR_WIDTH-1:0]         retire_addr,
   output logic [2:0]                    state,
   output logic                          done,
   output logic                          timeout,
   output logic                          deadlock,
   output logic [CNT_WIDTH-1:0]          cycle_count,
   output logic [CNT_WIDTH-1:0]          retire_count,
   output logic [ADDR_WIDTH-1:0]         last_addr,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
   output logic [ADDR_WIDTH-1:0]         hist_addr
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      DRAIN    = 3'd2,
      DONE     = 3'd3,
      TIMEOUT  = 3'd4,
      DEADLOCK = 3'd5
   } state_t;

   // Drain counter needs at least one bit even when draining is disabled.
   localparam int                   DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int                   CW1        = CNT_WIDTH + 1;
   localparam logic [DW-1:0]        DRAIN_INIT = DW'(DRAIN_CYCLES);
   localparam logic [DW-1:0]        DRAIN_ONE  = DW'(1);
   localparam logic [CW1-1:0]       MAX_C      = CW1'(MAX_CYCLES);
   localparam logic [CW1-1:0]       STALL_C    = CW1'(STALL_LIMIT);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic [CW1-1:0]       WIDE_ONE   = CW1'(1);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  cycle_count_q, cycle_count_d;
   logic [CNT_WIDTH-1:0]  retire_count_q, retire_count_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic [DW-1:0]         drain_cnt_q, drain_cnt_d;

   logic                  counted;
   logic [CNT_WIDTH-1:0]  cycle_inc, retire_inc, stall_inc;
   logic [CW1-1:0]        cycle_plus1, stall_plus1;

   // Saturating increments; the widened "+1" forms feed the exit comparisons so a
   // limit equal to 2**CNT_WIDTH still compares correctly.
   assign cycle_inc   = (&cycle_count_q)  ? cycle_count_q  : cycle_count_q + CNT_ONE;
   assign retire_inc  = (&retire_count_q) ? retire_count_q : retire_count_q + CNT_ONE;
   assign stall_inc   = (&stall_cnt_q)    ? stall_cnt_q    : stall_cnt_q + CNT_ONE;
   assign cycle_plus1 = {1'b0, cycle_count_q} + WIDE_ONE;
   assign stall_plus1 = {1'b0, stall_cnt_q} + WIDE_ONE;

   always_comb begin
      state_d        = state_q;
      cycle_count_d  = cycle_count_q;
      retire_count_d = retire_count_q;
      stall_cnt_d    = stall_cnt_q;
      last_addr_d    = last_addr_q;
      drain_cnt_d    = drain_cnt_q;
      counted        = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cycle_count_d = cycle_inc;
            counted       = retire_valid;
            stall_cnt_d   = retire_valid ? '0 : stall_inc;
            // Halt beats timeout beats deadlock when they land on the same cycle.
            if (retire_valid && (retire_addr == HALT_ADDR)) begin
               if (DRAIN_CYCLES == 0) begin
                  state_d = DONE;
               end else begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_INIT;
               end
            end else if (cycle_plus1 >= MAX_C) begin
               state_d = TIMEOUT;
            end else if (!retire_valid && (stall_plus1 >= STALL_C)) begin
               state_d = DEADLOCK;
            end
         end
         DRAIN: begin
            // Budget and stall checks are off here: the program already asked to stop.
            cycle_count_d = cycle_inc;
            counted       = retire_valid;
            drain_cnt_d   = drain_cnt_q - DRAIN_ONE;
            if (drain_cnt_q == DRAIN_ONE) begin
               state_d = DONE;
            end
         end
         default: begin
            // DONE / TIMEOUT / DEADLOCK hold everything until reset.
         end
      endcase

      if (counted) begin
         retire_count_d = retire_inc;
         last_addr_d    = retire_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         cycle_count_q  <= '0;
         retire_count_q <= '0;
         stall_cnt_q    <= '0;
         last_addr_q    <= '0;
         drain_cnt_q    <= '0;
      end else begin
         state_q        <= state_d;
         cycle_count_q  <= cycle_count_d;
         retire_count_q <= retire_count_d;
         stall_cnt_q    <= stall_cnt_d;
         last_addr_q    <= last_addr_d;
         drain_cnt_q    <= drain_cnt_d;
      end
   end

   assign state        = state_q;
   assign done         = (state_q == DONE);
   assign timeout      = (state_q == TIMEOUT);
   assign deadlock     = (state_q == DEADLOCK);
   assign cycle_count  = cycle_count_q;
   assign retire_count = retire_count_q;
   assign last_addr    = last_addr_q;

`ifdef RETIRE_MONITOR_HIST_EN
   localparam int HW = $clog2(HIST_DEPTH);

   logic [ADDR_WIDTH-1:0] hist_q [HIST_DEPTH];
   logic [ADDR_WIDTH-1:0] hist_d [HIST_DEPTH];
   logic [HW-1:0]         wptr_q, wptr_d;

   always_comb begin
      hist_d = hist_q;
      wptr_d = wptr_q;
      if (counted) begin
         hist_d[wptr_q] = retire_addr;
         wptr_d         = wptr_q + HW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_q[i] <= '0;
         end
         wptr_q <= '0;
      end else begin
         hist_q <= hist_d;
         wptr_q <= wptr_d;
      end
   end

   // wptr points at the next free slot, so the newest entry is one behind it; the
   // HW-bit subtraction gives the mod-HIST_DEPTH wrap for free.
   assign hist_addr = hist_q[wptr_q - HW'(1) - hist_idx];
`else
   logic unused_hist_idx;
   assign unused_hist_idx = ^hist_idx;
   assign hist_addr       = '0;
`endif

endmodule

// File: tb/tb_retire_monitor.sv
// tb_retire_monitor: randomized and directed retire streams against a reference model.
//    Each run's predicted outcome is queued at start; a negedge monitor pops it when the
//    DUT reaches a terminal state and compares status, counters and arrival edge.
module tb_retire_monitor;

   localparam int          AW      = 32;
   localparam int          CW      = 32;
   localparam logic [31:0] HALT    = 32'h0000_FFFC;
   localparam int          DRAIN   = 2;
   localparam int          MAXC    = 20;
   localparam int          STALL   = 8;
   localparam int          HDEPTH  = 8;
   localparam int          SEQ_LEN = 40;

   localparam logic [2:0] S_IDLE = 3'd0, S_DRAIN = 3'd2, S_DONE = 3'd3,
                          S_TIMEOUT = 3'd4, S_DEADLOCK = 3'd5;

   typedef struct {
      logic [2:0]  st;
      int          cyc;
      int          ret;
      logic [31:0] last;
      int          term_edge;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          retire_valid = 1'b0;
   logic [AW-1:0] retire_addr = '0;
   logic [2:0]    state;
   logic          done, timeout, deadlock;
   logic [CW-1:0] cycle_count, retire_count;
   logic [AW-1:0] last_addr;
   logic [2:0]    hist_idx = '0;
   logic [AW-1:0] hist_addr;

   int          n_checks = 0;
   int          n_fail = 0;
   int          edge_cnt = 0;
   string       cur_name = "init";
   exp_t        exp_q[$];
   logic [31:0] hist_model[$];
   logic        seq_vld [SEQ_LEN];
   logic [31:0] seq_addr [SEQ_LEN];

   retire_monitor #(
      .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .HALT_ADDR(HALT), .DRAIN_CYCLES(DRAIN),
      .MAX_CYCLES(MAXC), .STALL_LIMIT(STALL), .HIST_DEPTH(HDEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .retire_valid(retire_valid),
      .retire_addr(retire_addr), .state(state), .done(done), .timeout(timeout),
      .deadlock(deadlock), .cycle_count(cycle_count), .retire_count(retire_count),
      .last_addr(last_addr), .hist_idx(hist_idx), .hist_addr(hist_addr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h, expected %0h", cur_name, nm, act, exp);
      end
   endtask

   // Reference: walk the stimulus cycle by cycle as the run rules describe.
   task automatic model(output exp_t e);
      int cyc = 0, ret = 0, stall = 0, left = 0;
      bit in_drain = 0, fin = 0;
      logic [31:0] last = '0;
      hist_model.delete();
      e.st = S_IDLE;
      for (int k = 0; k < SEQ_LEN && !fin; k++) begin
         cyc++;
         if (seq_vld[k]) begin
            ret++;
            last = seq_addr[k];
            hist_model.push_front(seq_addr[k]);
         end
         if (in_drain) begin
            left--;
            if (left == 0) begin fin = 1; e.st = S_DONE; end
         end else if (seq_vld[k] && seq_addr[k] == HALT) begin
            if (DRAIN == 0) begin fin = 1; e.st = S_DONE; end
            else begin in_drain = 1; left = DRAIN; end
         end else if (cyc >= MAXC) begin
            fin = 1; e.st = S_TIMEOUT;
         end else if (seq_vld[k]) begin
            stall = 0;
         end else begin
            stall++;
            if (stall >= STALL) begin fin = 1; e.st = S_DEADLOCK; end
         end
      end
      e.cyc = cyc;
      e.ret = ret;
      e.last = last;
      e.term_edge = 0;
   endtask

   // Monitor: fires on the first cycle a terminal status appears while a run is pending.
   initial begin
      exp_t me;
      forever begin
         @(negedge clk);
         if ((done || timeout || deadlock) && exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("state", 64'(state), 64'(me.st));
            chk("done", 64'(done), 64'(me.st == S_DONE));
            chk("timeout", 64'(timeout), 64'(me.st == S_TIMEOUT));
            chk("deadlock", 64'(deadlock), 64'(me.st == S_DEADLOCK));
            chk("cycle_count", 64'(cycle_count), 64'(me.cyc));
            chk("retire_count", 64'(retire_count), 64'(me.ret));
            chk("last_addr", 64'(last_addr), 64'(me.last));
            chk("term_edge", 64'(edge_cnt), 64'(me.term_edge));
         end
      end
   end

   task automatic check_hist();
      logic [31:0] want;
      for (int i = 0; i < HDEPTH; i++) begin
         hist_idx = 3'(i);
         #1;
`ifdef RETIRE_MONITOR_HIST_EN
         want = (i < hist_model.size()) ? hist_model[i] : 32'd0;
`else
         want = 32'd0;
`endif
         chk($sformatf("hist[%0d]", i), 64'(hist_addr), 64'(want));
      end
      hist_idx = '0;
   endtask

   task automatic reset_dut();
      @(posedge clk);
      #3 rst = 1'b1;
      start = 1'b0;
      retire_valid = 1'b0;
      #1;
      chk("rst_state", 64'(state), 64'(S_IDLE));
      chk("rst_flags", 64'({done, timeout, deadlock}), 64'd0);
      chk("rst_cycle", 64'(cycle_count), 64'd0);
      chk("rst_retire", 64'(retire_count), 64'd0);
      chk("rst_last", 64'(last_addr), 64'd0);
      chk("rst_hist", 64'(hist_addr), 64'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      // Retires while IDLE must not be counted, not even a halt.
      @(posedge clk); #1;
      retire_valid = 1'b1;
      retire_addr = HALT;
      @(posedge clk); #1;
      retire_valid = 1'b0;
      chk("idle_state", 64'(state), 64'(S_IDLE));
      chk("idle_retire", 64'(retire_count), 64'd0);
      chk("idle_cycle", 64'(cycle_count), 64'd0);
   endtask

   task automatic run_seq(input string name);
      exp_t e;
      cur_name = name;
      model(e);
      @(posedge clk); #1;
      e.term_edge = edge_cnt + 1 + e.cyc;
      exp_q.push_back(e);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
         retire_valid = seq_vld[k];
         retire_addr = seq_addr[k];
         start = ($urandom_range(0, 3) == 0);   // must be ignored in every state
         @(posedge clk); #1;
      end
      retire_valid = 1'b0;
      start = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s/terminal: no terminal state within %0d cycles, expected %0d", name, SEQ_LEN, e.st);
         exp_q.delete();
      end
      // Terminal state is sticky and counters stay frozen despite later stimulus.
      chk("sticky_state", 64'(state), 64'(e.st));
      chk("frozen_cycle", 64'(cycle_count), 64'(e.cyc));
      chk("frozen_retire", 64'(retire_count), 64'(e.ret));
      chk("frozen_last", 64'(last_addr), 64'(e.last));
      check_hist();
   endtask

   task automatic clear_seq();
      for (int k = 0; k < SEQ_LEN; k++) begin
         seq_vld[k] = 1'b0;
         seq_addr[k] = 32'h0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pvs[5] = '{100, 90, 70, 30, 5};
      int pv, hpos;

      // T1: three retires then halt, drain of 2.
      reset_dut();
      clear_seq();
      for (int k = 0; k < 4; k++) begin seq_vld[k] = 1'b1; seq_addr[k] = 32'(4 * k); end
      seq_addr[3] = HALT;
      run_seq("t1_halt");

      // T2: retire every cycle, never halt -> timeout.
      reset_dut();
      for (int k = 0; k < SEQ_LEN; k++) begin seq_vld[k] = 1'b1; seq_addr[k] = 32'(4 * k); end
      run_seq("t2_timeout");

      // T3: never retire -> deadlock.
      reset_dut();
      clear_seq();
      run_seq("t3_deadlock");

      // T4: halt retires on the cycle the budget would expire.
      reset_dut();
      for (int k = 0; k < SEQ_LEN; k++) begin seq_vld[k] = 1'b1; seq_addr[k] = 32'(4 * k); end
      seq_addr[MAXC-1] = HALT;
      run_seq("t4_halt_vs_timeout");

      // T5: asynchronous reset mid-cycle while draining, then a clean restart.
      reset_dut();
      cur_name = "t5_async_rst";
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      retire_valid = 1'b1;
      retire_addr = HALT;
      @(posedge clk); #1;
      retire_valid = 1'b0;
      chk("in_drain", 64'(state), 64'(S_DRAIN));
      #2 rst = 1'b1;
      #1;
      chk("state", 64'(state), 64'(S_IDLE));
      chk("outs", 64'({done, timeout, deadlock}), 64'd0);
      chk("counts", 64'({cycle_count, retire_count}), 64'd0);
      chk("last", 64'(last_addr), 64'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      clear_seq();
      for (int k = 0; k < 4; k++) begin seq_vld[k] = 1'b1; seq_addr[k] = 32'(4 * k); end
      seq_addr[3] = HALT;
      run_seq("t5_restart");

      // T6: ten retires 0x100+4k then stall out; history holds the newest eight.
      reset_dut();
      clear_seq();
      for (int k = 0; k < 10; k++) begin seq_vld[k] = 1'b1; seq_addr[k] = 32'h100 + 32'(4 * k); end
      run_seq("t6_history");

      // Randomized runs of varying retire density, with and without a halt.
      for (int r = 0; r < 14; r++) begin
         reset_dut();
         pv = pvs[$urandom_range(0, 4)];
         hpos = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 24)) : -1;
         for (int k = 0; k < SEQ_LEN; k++) begin
            seq_vld[k] = ($urandom_range(0, 99) < pv);
            seq_addr[k] = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
         end
         if (hpos >= 0) begin
            seq_vld[hpos] = 1'b1;
            seq_addr[hpos] = HALT;
         end
         run_seq($sformatf("rand%0d_p%0d_h%0d", r, pv, hpos));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
